// File: rtl/sub_pkg.sv
// Shared definitions for the sequential borrow-lookahead subtractor.
//   state_t       : control FSM states (IDLE, RUN, DONE)
//   SLICE_W       : width of one borrow-lookahead slice
//   slice_count() : number of slices needed to cover a given operand width
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int slice_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/borrow_lookahead_slice.sv
// Combinational 4-bit borrow-lookahead subtract slice: d = a - b - bin.
//   a, b : 4-bit slice operands
//   bin  : borrow into bit 0
//   d    : 4-bit slice difference
//   bout : borrow out of bit 3
module borrow_lookahead_slice
  import sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   br;

  // g: this bit borrows regardless of the incoming borrow (a=0, b=1).
  // p: the incoming borrow passes through unchanged (a == b).
  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Fully expanded lookahead terms, so no ripple path through the slice.
  assign br[0] = bin;
  assign br[1] = g[0] | (p[0] & bin);
  assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bin);
  assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);

  assign d    = a ^ b ^ br[SLICE_W-1:0];
  assign bout = br[SLICE_W];

endmodule

// File: rtl/seq_borrow_lookahead_subtractor.sv
// Multi-cycle subtractor: diff = (a - b - bin) mod 2^WIDTH, one 4-bit
// borrow-lookahead slice per clock, LSB slice first, behind a valid/ready
// handshake on both sides.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (accepted only in IDLE)
//   a, b, bin            : minuend, subtrahend, borrow-in
//   out_valid / out_ready: result handshake (held in DONE until taken)
//   diff                 : difference word
//   bout                 : unsigned borrow-out (a < b + bin)
//   zero                 : diff == 0
//   ovf                  : two's-complement overflow
module seq_borrow_lookahead_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NSL   = slice_count(WIDTH);
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

  generate
    if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
      $error("seq_borrow_lookahead_subtractor: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t             state_q, state_d;

  logic [WIDTH-1:0]   a_p0, b_p0;
  logic               brw_p0;
  logic [IDX_W-1:0]   idx_p0;

  logic [WIDTH-1:0]   diff_p1;
  logic               bout_p1, zero_p1, ovf_p1;

  logic [SLICE_W-1:0] a_sl, b_sl, d_sl;
  logic               bo_sl;
  logic [WIDTH-1:0]   diff_nxt;
  logic               last_sl;

  // Select the active slice of the captured operands and merge the slice
  // result into the word; explicit compare-per-slice keeps widths exact.
  always_comb begin
    a_sl     = '0;
    b_sl     = '0;
    diff_nxt = diff_p1;
    for (int k = 0; k < NSL; k++) begin
      if (idx_p0 == IDX_W'(k)) begin
        a_sl = a_p0[k*SLICE_W +: SLICE_W];
        b_sl = b_p0[k*SLICE_W +: SLICE_W];
        diff_nxt[k*SLICE_W +: SLICE_W] = d_sl;
      end
    end
  end

  assign last_sl = (idx_p0 == IDX_W'(NSL - 1));

  borrow_lookahead_slice u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .bin  (brw_p0),
    .d    (d_sl),
    .bout (bo_sl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_sl) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_p0    <= '0;
      b_p0    <= '0;
      brw_p0  <= 1'b0;
      idx_p0  <= '0;
      diff_p1 <= '0;
      bout_p1 <= 1'b0;
      zero_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        // stage p0: operand capture; borrow register seeded with bin
        IDLE: begin
          if (in_valid) begin
            a_p0   <= a;
            b_p0   <= b;
            brw_p0 <= bin;
            idx_p0 <= '0;
          end
        end
        // stage p1: one slice per cycle into the result word; flags on the last
        RUN: begin
          diff_p1 <= diff_nxt;
          brw_p0  <= bo_sl;
          idx_p0  <= idx_p0 + 1'b1;
          if (last_sl) begin
            bout_p1 <= bo_sl;
            zero_p1 <= (diff_nxt == '0);
            ovf_p1  <= (a_p0[WIDTH-1] != b_p0[WIDTH-1]) &&
                       (diff_nxt[WIDTH-1] != a_p0[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_p1;
  assign bout      = bout_p1;
  assign zero      = zero_p1;
  assign ovf       = ovf_p1;

endmodule

// File: tb/tb_seq_borrow_lookahead_subtractor.sv
// Scoreboard bench for seq_borrow_lookahead_subtractor (WIDTH=16).
// The driver pushes hand-computed expectations when an operand is accepted;
// the monitor pops and compares on every out_valid && out_ready cycle.
module tb_seq_borrow_lookahead_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout, zero, ovf;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         o;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  seq_borrow_lookahead_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one operand set; if push, record the expectation at the accept edge.
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                      input logic [W-1:0] ed, input logic ebo, input logic ez,
                      input logic eo, input bit push);
    int n;
    exp_t e;
    @(negedge clk);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) begin
      e.d = ed; e.bo = ebo; e.z = ez; e.o = eo; e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", q.size(), 32'd0);
  endtask

  // Monitor: sample mid-low-phase, away from the rising edge and the driver.
  initial begin
    logic prev_vld;
    exp_t e;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && !prev_vld && q.size() != 0)
        chk("latency", cyc - q[0].acc, 32'd4);
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("diff", diff, e.d);
          chk("bout", bout, e.bo);
          chk("zero", zero, e.z);
          chk("ovf",  ovf,  e.o);
        end
      end
      prev_vld = out_valid;
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_diff", diff, 32'd0);
    chk("rst_flags", {bout, zero, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 32'd1);

    // Directed vectors: a, b, bin, diff, bout, zero, ovf
    send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1);
    send(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);
    send(16'h5A5A, 16'h5A59, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    send(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    send(16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reached_done", out_valid, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = 16'h1111 * (i + 1);
      b = 16'h0F0F ^ a;
      bin = in_valid;
      #2;
      chk("stall_out_valid", out_valid, 32'd1);
      chk("stall_in_ready", in_ready, 32'd0);
      chk("stall_diff", diff, 32'h0000FFFE);
      chk("stall_flags", {bout, zero, ovf}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    a = 16'h0003; b = 16'h0003; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("handshake_in_ready", in_ready, 32'd1);
    @(posedge clk);
    #1;
    chk("accept_after_done", in_ready, 32'd0);
    begin
      exp_t e;
      e.d = 16'h0000; e.bo = 1'b0; e.z = 1'b1; e.o = 1'b0; e.acc = cyc;
      q.push_back(e);
    end
    in_valid = 1'b0;
    drain();

    // Reset in the middle of RUN: operation discarded, no output.
    send(16'h1111, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 32'd0);
    chk("midrst_diff", diff, 32'd0);
    chk("midrst_flags", {bout, zero, ovf}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_hold_out_valid", out_valid, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2;
      chk("after_rst_no_output", out_valid, 32'd0);
    end
    send(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
